// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with one write port and two
// registered read ports (A, B). Reads have one cycle of latency and see a
// same-cycle write to the same address (write-first bypass). After reset a
// sequential clear engine zeroes every entry; requests are ignored while busy.
// Optional macro REGFILE_ZERO_REG_EN: entry 0 reads as zero, writes to it drop.
module regfile_2r1w #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re_a,
    input  logic [ADDR_BITS-1:0] raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    output logic                 rvalid_a,
    input  logic                 re_b,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_b,
    output logic                 rvalid_b,
    output logic                 busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_clr_idx;
    logic [ADDR_BITS-1:0] w_clr_idx_nxt;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [WIDTH-1:0]     r_rdata_a, r_rdata_b;
    logic                 r_rvalid_a, r_rvalid_b;

    logic                 w_ready;
    logic                 w_wr_en;
    logic [WIDTH-1:0]     w_rd_a, w_rd_b;

    assign w_ready = (r_state == S_READY);

    // A write only lands in READY; with the zero register, address 0 is dropped
    // here so the bypass path never forwards it either.
    always_comb begin
        w_wr_en = we && w_ready;
`ifdef REGFILE_ZERO_REG_EN
        if (waddr == '0)
            w_wr_en = 1'b0;
`endif
    end

    // FSM state and clear index register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Next state: walk the clear index once, then stay READY until reset
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        if (r_state == S_CLEAR) begin
            w_clr_idx_nxt = r_clr_idx + 1'b1;
            if (r_clr_idx == {ADDR_BITS{1'b1}})
                w_state_nxt = S_READY;
        end
    end

    // Storage: clear engine owns the write port in CLEAR; nothing is written
    // during a reset cycle so contents survive until the clear reaches them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR)
                r_mem[r_clr_idx] <= '0;
            else if (w_wr_en)
                r_mem[waddr] <= wdata;
        end
    end

    // Port A read mux with write-first bypass
    always_comb begin
        w_rd_a = r_mem[raddr_a];
        if (w_wr_en && (waddr == raddr_a))
            w_rd_a = wdata;
`ifdef REGFILE_ZERO_REG_EN
        if (raddr_a == '0)
            w_rd_a = '0;
`endif
    end

    // Port B read mux with write-first bypass
    always_comb begin
        w_rd_b = r_mem[raddr_b];
        if (w_wr_en && (waddr == raddr_b))
            w_rd_b = wdata;
`ifdef REGFILE_ZERO_REG_EN
        if (raddr_b == '0)
            w_rd_b = '0;
`endif
    end

    // Port A output register: zero while clearing, hold data when idle
    always_ff @(posedge clk) begin
        if (rst || !w_ready) begin
            r_rdata_a  <= '0;
            r_rvalid_a <= 1'b0;
        end else begin
            r_rvalid_a <= re_a;
            if (re_a)
                r_rdata_a <= w_rd_a;
        end
    end

    // Port B output register: zero while clearing, hold data when idle
    always_ff @(posedge clk) begin
        if (rst || !w_ready) begin
            r_rdata_b  <= '0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_b <= re_b;
            if (re_b)
                r_rdata_b <= w_rd_b;
        end
    end

    assign rdata_a  = r_rdata_a;
    assign rvalid_a = r_rvalid_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_b = r_rvalid_b;
    assign busy     = ~w_ready;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed steps followed by a randomized run, every cycle
// compared against a behavioural model of the register file.
module tb_regfile_2r1w;

    localparam int W  = 16;
    localparam int AB = 4;
    localparam int D  = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [AB-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [W-1:0]  wdata = '0;
    logic [W-1:0]  rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, busy;

    regfile_2r1w #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: contents, cycles of clearing left, expected outputs
    logic [W-1:0] m_mem [D];
    int           m_left = D;
    logic [W-1:0] e_rd_a = '0, e_rd_b = '0;
    logic         e_rv_a = 1'b0, e_rv_b = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge's worth of behaviour to the model
    task automatic model_step();
        if (rst) begin
            m_left = D;
            e_rv_a = 1'b0; e_rv_b = 1'b0; e_rd_a = '0; e_rd_b = '0;
        end else if (m_left > 0) begin
            m_mem[D - m_left] = '0;
            m_left--;
            e_rv_a = 1'b0; e_rv_b = 1'b0; e_rd_a = '0; e_rd_b = '0;
        end else begin
            if (we && !(ZR && waddr == '0))
                m_mem[waddr] = wdata;
            e_rv_a = re_a;
            e_rv_b = re_b;
            if (re_a) e_rd_a = m_mem[raddr_a];
            if (re_b) e_rd_b = m_mem[raddr_b];
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("busy",     32'(busy),     32'(m_left > 0));
        chk("rvalid_a", 32'(rvalid_a), 32'(e_rv_a));
        chk("rvalid_b", 32'(rvalid_b), 32'(e_rv_b));
        chk("rdata_a",  32'(rdata_a),  32'(e_rd_a));
        chk("rdata_b",  32'(rdata_b),  32'(e_rd_b));
    endtask

    task automatic idle();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [W-1:0] d);
        idle(); we = 1'b1; waddr = a; wdata = d; cyc(); idle();
    endtask

    task automatic rd2(input logic [AB-1:0] a, input logic [AB-1:0] b);
        idle(); re_a = 1'b1; raddr_a = a; re_b = 1'b1; raddr_b = b; cyc(); idle();
    endtask

    // Count cycles with busy high, bounded
    task automatic count_busy(input string tag);
        int cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            cyc();
        end
        chk(tag, 32'(cnt), 32'(D));
    endtask

    initial begin
        for (int i = 0; i < D; i++) m_mem[i] = '0;

        // 1. reset clear and full readback
        rst = 1'b1; cyc(); cyc();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        rst = 1'b0;
        count_busy("t1_busy_cycles");
        for (int i = 0; i < D; i++) begin
            rd2(AB'(i), AB'(D - 1 - i));
            chk("t1_rd_a", 32'(rdata_a), 32'h0);
            chk("t1_rv_b", 32'(rvalid_b), 32'd1);
        end

        // 2. write then read
        wr(4'd3, 16'hBEEF);
        wr(4'd7, 16'h1234);
        rd2(4'd3, 4'd7);
        chk("t2_rd_a", 32'(rdata_a), 32'hBEEF);
        chk("t2_rd_b", 32'(rdata_b), 32'h1234);
        chk("t2_rv_a", 32'(rvalid_a), 32'd1);
        // idle cycle: valid drops, data holds
        cyc();
        chk("t2_hold_rv", 32'(rvalid_a), 32'd0);
        chk("t2_hold_rd", 32'(rdata_a), 32'hBEEF);

        // 3. write-first bypass on both ports
        wr(4'd5, 16'h0001);
        we = 1'b1; waddr = 4'd5; wdata = 16'hA5A5;
        re_a = 1'b1; raddr_a = 4'd5; re_b = 1'b1; raddr_b = 4'd5;
        cyc(); idle();
        chk("t3_byp_a", 32'(rdata_a), 32'hA5A5);
        chk("t3_byp_b", 32'(rdata_b), 32'hA5A5);

        // 4. requests ignored while clearing
        wr(4'd2, 16'h2222);
        rst = 1'b1; cyc(); rst = 1'b0;
        we = 1'b1; waddr = 4'd2; wdata = 16'hFFFF; re_a = 1'b1; raddr_a = 4'd2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_rv_busy", 32'(rvalid_a), 32'd0);
        end
        idle();
        while (busy && m_left > 0) cyc();
        rd2(4'd2, 4'd2);
        chk("t4_rd_a", 32'(rdata_a), 32'h0);

        // 5. reset in the middle of a clear
        wr(4'd12, 16'h7777);
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        count_busy("t5_busy_cycles");
        rd2(4'd12, 4'd12);
        chk("t5_rd_a", 32'(rdata_a), 32'h0);

`ifdef REGFILE_ZERO_REG_EN
        // 6. hardwired zero entry
        wr(4'd0, 16'h9999);
        rd2(4'd0, 4'd0);
        chk("t6_rd_a", 32'(rdata_a), 32'h0);
        chk("t6_rd_b", 32'(rdata_b), 32'h0);
        we = 1'b1; waddr = 4'd0; wdata = 16'h9999; re_a = 1'b1; raddr_a = 4'd0;
        cyc(); idle();
        chk("t6_byp_a", 32'(rdata_a), 32'h0);
`endif

        // 7. randomized traffic with rare resets
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            we      = $urandom_range(0, 1) == 1;
            waddr   = AB'($urandom);
            wdata   = W'($urandom);
            re_a    = $urandom_range(0, 2) != 0;
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : AB'($urandom);
            re_b    = $urandom_range(0, 2) != 0;
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : AB'($urandom);
            cyc();
        end
        rst = 1'b0; idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
